clk_div_prog: RTL and testbench

//  Runtime-programmable integer clock divider: clk_out = clk_in / N, N in [2, 2^DIV_W-1].

---
 rtl/clk_div_prog.sv | 138 +++++++++++++
 tb/tb_clk_div_prog.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable integer clock divider, clk_out = clk_in / N with a 50%
// duty cycle for both even and odd N (odd N adds a negedge half-cycle flop).
// Ratio changes and start/stop only take effect at period boundaries, so
// clk_out never produces a runt pulse during normal operation.
//
// Optional feature macro: CLK_DIV_PROG_TICK_EN
//   defined     -> tick pulses for one clk_in cycle at each period start
//   not defined -> tick is tied to 0 and its logic is removed
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_pending,
    output logic             running,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] N_DEFAULT = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] N_MIN     = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] cur_n, cur_n_d;
    logic [DIV_W-1:0] shadow, shadow_d;
    logic             pending, pending_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic [DIV_W-1:0] half_d;
    logic             boundary;
    logic             apply;

    // Next-state decode: counter, ratio shadowing and the high-phase flag.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state;
        cnt_d     = cnt;
        cur_n_d   = cur_n;
        shadow_d  = shadow;
        pending_d = pending;

        boundary = (state == ST_RUN) && (cnt == cur_n - ONE);
        apply    = pending && ((state == ST_IDLE) || boundary);

        // The applied value is the shadow as it stood before this edge, so a
        // load arriving in the boundary cycle waits for the next boundary.
        if (apply) begin
            cur_n_d   = shadow;
            pending_d = 1'b0;
        end
        if (div_load) begin
            shadow_d  = (div_ratio < N_MIN) ? N_MIN : div_ratio;
            pending_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (!en) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // High for the first ceil(N/2) counts of each period; written without
        // N+1 so the maximum ratio cannot overflow the DIV_W-bit field.
        half_d = (cur_n_d >> 1) + {{(DIV_W-1){1'b0}}, cur_n_d[0]};
        pos_d  = (state_d == ST_RUN) && (cnt_d < half_d);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_n   <= N_DEFAULT;
            shadow  <= N_DEFAULT;
            pending <= 1'b0;
            pos_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cur_n   <= cur_n_d;
            shadow  <= shadow_d;
            pending <= pending_d;
            pos_q   <= pos_d;
        end
    end

    // Half-cycle delayed copy of the high phase, used to centre odd ratios.
    always_ff @(negedge clk_in) begin
        if (!reset_n) neg_q <= 1'b0;
        else          neg_q <= pos_q;
    end

    // Odd ratios AND the two phases: rises half a cycle late, high N/2 cycles.
    assign clk_out     = cur_n[0] ? (pos_q & neg_q) : pos_q;
    assign running     = (state == ST_RUN);
    assign div_pending = pending;

`ifdef CLK_DIV_PROG_TICK_EN
    // Period-start pulse: high through the cycle in which cnt==0 while running.
    always_ff @(posedge clk_in) begin
        if (!reset_n) tick <= 1'b0;
        else          tick <= (state_d == ST_RUN) && (cnt_d == '0);
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog. A reference model tracks the period
// position and ratio; the expected clk_out comes from treating each period as
// 2N half-cycle slots of which N consecutive slots are high (offset by one
// slot for odd N). Outputs are compared one time unit after every clock edge.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int DIV_W       = 8;
    localparam int DIV_DEFAULT = 3;

    logic             clk_in = 1'b0;
    logic             reset_n;
    logic             en;
    logic [DIV_W-1:0] div_ratio;
    logic             div_load;
    logic             div_pending;
    logic             running;
    logic             clk_out;
    logic             tick;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_run;
    int m_p;
    int m_n;
    int m_shadow;
    bit m_pend;

    clk_div_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .en         (en),
        .div_ratio  (div_ratio),
        .div_load   (div_load),
        .div_pending(div_pending),
        .running    (running),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Expected divided clock for half-cycle slot s of the current period.
    function automatic logic exp_clk(input int slot);
        int off;
        off = m_n % 2;
        return m_run && (slot >= off) && (slot < off + m_n);
    endfunction

    // Advance the model by one source-clock posedge using the sampled inputs.
    task automatic model_step();
        bit boundary;
        bit apply;
        if (!reset_n) begin
            m_run    = 1'b0;
            m_p      = 0;
            m_n      = DIV_DEFAULT;
            m_shadow = DIV_DEFAULT;
            m_pend   = 1'b0;
        end else begin
            boundary = m_run && (m_p == m_n - 1);
            apply    = m_pend && (!m_run || boundary);
            if (!m_run) begin
                if (apply) m_n = m_shadow;
                if (en) begin
                    m_run = 1'b1;
                    m_p   = 0;
                end
            end else if (boundary) begin
                if (apply) m_n = m_shadow;
                m_p = 0;
                if (!en) m_run = 1'b0;
            end else begin
                m_p++;
            end
            if (apply) m_pend = 1'b0;
            if (div_load) begin
                m_shadow = (int'(div_ratio) < 2) ? 2 : int'(div_ratio);
                m_pend   = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
        check("clk_out_hi_half", clk_out, exp_clk(2 * m_p));
        check("running", running, m_run);
        check("div_pending", div_pending, m_pend);
`ifdef CLK_DIV_PROG_TICK_EN
        check("tick", tick, m_run && (m_p == 0));
`else
        check("tick_off", tick, 1'b0);
`endif
        @(negedge clk_in);
        #1;
        check("clk_out_lo_half", clk_out, exp_clk(2 * m_p + 1));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input int val);
        div_ratio = DIV_W'(val);
        div_load  = 1'b1;
        cycle();
        div_load  = 1'b0;
    endtask

    // Bounded advance until the model reaches position p of an N-period.
    task automatic run_until(input int n, input int p);
        for (int i = 0; i < 600; i++) begin
            if (m_run && m_n == n && m_p == p) break;
            cycle();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        div_ratio = '0;
        div_load  = 1'b0;

        // Reset state
        run(2);
        reset_n = 1'b1;
        run(2);

        // Default N=3, odd duty
        en = 1'b1;
        run(12);

        // Load N=4 mid-period
        run_until(3, 1);
        load(4);
        run(14);

        // Load 5 then 6 before the boundary: only 6 applies
        run_until(4, 0);
        load(5);
        load(6);
        run(20);

        // Load in the boundary cycle itself
        run_until(6, 5);
        load(8);
        run(20);

        // en low then high within one period: no effect
        run_until(8, 2);
        en = 1'b0;
        cycle();
        en = 1'b1;
        run(10);

        // Stop request at cnt=1 of N=8, then restart
        run_until(8, 0);
        cycle();
        en = 1'b0;
        run(14);
        en = 1'b1;
        run(18);

        // Clamp N=0 and N=1 to 2
        load(0);
        run(10);
        load(1);
        run(10);

        // Ratio load while stopped applies on the next posedge
        run_until(2, 1);
        en = 1'b0;
        run(4);
        load(5);
        run(3);
        en = 1'b1;
        run(16);

        // Reset while clk_out high with N=7
        load(7);
        run_until(7, 1);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        run(14);

        // Maximum ratio
        load(255);
        run(520);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 11) != 0);
            div_load  = ($urandom_range(0, 14) == 0);
            div_ratio = DIV_W'($urandom_range(0, 13));
            reset_n   = ($urandom_range(0, 399) != 0);
            cycle();
        end
        div_load = 1'b0;
        reset_n  = 1'b1;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
